// File: rtl/spm_pkg.sv
// Shared types and defaults for the serial-parallel multiplier sequencer.
package spm_pkg;

  // Controller phases: accept, clear the csa chain, stream, present result.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefXw     = 8;
  localparam int unsigned DefYw     = 8;
  localparam int unsigned DefSpmLat = 1;

  // Bits needed to hold 0..n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spm_serdes.sv
// Multiplier shift-out and product shift-in for the serial-parallel array.
// The y register feeds the array LSB-first; the product register collects
// returned bits MSB-first so the word ends up LSB-aligned.
module spm_serdes
  import spm_pkg::*;
#(
  parameter int unsigned XW      = DefXw,
  parameter int unsigned YW      = DefYw,
  parameter int unsigned SPM_LAT = DefSpmLat,
  parameter int unsigned CW      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [YW-1:0]      i_y,
  input  logic               i_run,
  input  logic [CW-1:0]      i_cnt,
  input  logic               i_spm_p,
  output logic               o_spm_y,
  output logic [XW+YW-1:0]   o_p
);

  localparam int unsigned PW = XW + YW;
  localparam logic [CW-1:0] YwC = CW'(YW);

  logic [YW-1:0] r_yreg;
  logic [PW-1:0] r_preg;
  logic          w_cap;

  // Product bits only become meaningful once the array latency has elapsed.
  if (SPM_LAT == 0) begin : g_cap_always
    assign w_cap = 1'b1;
  end else begin : g_cap_gated
    localparam logic [CW-1:0] LatC = CW'(SPM_LAT);
    assign w_cap = (i_cnt >= LatC);
  end

  // Load operands on accept, then shift both registers while streaming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_yreg <= '0;
      r_preg <= '0;
    end else if (i_load) begin
      r_yreg <= i_y;
      r_preg <= '0;
    end else if (i_run) begin
      r_yreg <= r_yreg >> 1;
      if (w_cap) begin
        r_preg <= {i_spm_p, r_preg[PW-1:1]};
      end
    end
  end

  // Zero-fill after the last multiplier bit flushes the carry chain.
  always_comb begin
    o_spm_y = i_run && (i_cnt < YwC) && r_yreg[0];
  end

  assign o_p = r_preg;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier: accepts one operand pair,
// clears the csa chain, streams the multiplier and returns the full product.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int unsigned XW      = DefXw,
  parameter int unsigned YW      = DefYw,
  parameter int unsigned SPM_LAT = DefSpmLat
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XW-1:0]      in_x,
  input  logic [YW-1:0]      in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XW+YW-1:0]   out_p,
  output logic               busy,
  output logic               spm_clr,
  output logic [XW-1:0]      spm_x,
  output logic               spm_y,
  input  logic               spm_p
);

  // Stream length: every product bit plus the array pipeline delay.
  localparam int unsigned N  = XW + YW + SPM_LAT;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_spm_x;
  logic          r_spm_clr;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_run;

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_run    = (r_state == StRun);

  // Main FSM; all handshake and array-control outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_spm_x     <= '0;
      r_spm_clr   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_spm_x   <= in_x;
            r_spm_clr <= 1'b1;
            r_state   <= StClear;
          end
        end
        StClear: begin
          r_spm_clr <= 1'b0;
          r_cnt     <= '0;
          r_state   <= StRun;
        end
        StRun: begin
          if (r_cnt == CntLast) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  spm_serdes #(
    .XW      (XW),
    .YW      (YW),
    .SPM_LAT (SPM_LAT),
    .CW      (CW)
  ) u_serdes (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_y     (in_y),
    .i_run   (w_run),
    .i_cnt   (r_cnt),
    .i_spm_p (spm_p),
    .o_spm_y (spm_y),
    .o_p     (out_p)
  );

  // Readiness and busy are pure state decodes, so no input reaches them.
  always_comb begin
    in_ready = (r_state == StIdle);
    busy     = (r_state != StIdle);
  end

  assign out_valid = r_out_valid;
  assign spm_clr   = r_spm_clr;
  assign spm_x     = r_spm_x;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl: three instances (SPM_LAT 1, 0, 3), each wired to a
// behavioural serial-parallel array; products checked against x*y.
module tb_spm_seq_ctrl;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;

  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        busy      [NI];
  logic        spm_clr   [NI];
  logic        spm_y     [NI];
  logic        spm_p     [NI];
  logic [15:0] out_p     [NI];
  logic [7:0]  spm_x     [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    // Array model: running sum of x shifted by the bit index of each y bit;
    // product bit k is settled once y bit k has been added.
    logic [63:0] m_s;
    logic [63:0] m_sum;
    logic [5:0]  m_k;
    logic        m_b;
    logic [3:0]  m_pipe;

    spm_seq_ctrl #(
      .XW      (8),
      .YW      (8),
      .SPM_LAT (L)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_x      (in_x),
      .in_y      (in_y),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_p     (out_p[g]),
      .busy      (busy[g]),
      .spm_clr   (spm_clr[g]),
      .spm_x     (spm_x[g]),
      .spm_y     (spm_y[g]),
      .spm_p     (spm_p[g])
    );

    always_comb begin
      m_sum = m_s + (spm_y[g] ? ({56'd0, spm_x[g]} << m_k) : 64'd0);
      m_b   = m_sum[m_k];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_s    <= '0;
        m_k    <= '0;
        m_pipe <= '0;
      end else begin
        if (spm_clr[g]) begin
          m_s <= '0;
          m_k <= '0;
        end else begin
          m_s <= m_sum;
          if (m_k < 6'd40) m_k <= m_k + 6'd1;
        end
        m_pipe <= {m_pipe[2:0], m_b};
      end
    end

    assign spm_p[g] = (L == 0) ? m_b : m_pipe[(L == 0) ? 0 : L - 1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_yseq(input logic [7:0] y);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k] = y[k];
    return r;
  endfunction

  // Issue one op to instance 0 and follow it to the first out_valid cycle.
  // Cycle numbers count from the accept cycle (0).
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic rdy,
                        output int lat, output int clr_n, output int clr_at,
                        output logic [31:0] yseq, output int ny);
    int c;
    lat = -1; clr_n = 0; clr_at = -1; yseq = '0; ny = 0;
    in_x = x; in_y = y; in_valid = 1'b1; out_ready = rdy;
    c = 0;
    while (!in_ready[0] && c < 100) begin
      step();
      c++;
    end
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready[0]);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 60; k++) begin
      if (spm_clr[0]) begin
        clr_n++;
        if (clr_at < 0) clr_at = k;
      end
      if (busy[0] && !spm_clr[0] && !out_valid[0] && ny < 32) begin
        yseq[ny] = spm_y[0];
        ny++;
      end
      if (out_valid[0]) begin
        lat = k;
        break;
      end
      step();
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL out_valid_timeout got none within 60 cycles required cycle 19");
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    in_x = 8'h5A;
    in_y = 8'h33;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if (out_valid[0] !== 1'b0 || spm_clr[0] !== 1'b0 || spm_y[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl valid/clr/y=%b%b%b required 000",
               out_valid[0], spm_clr[0], spm_y[0]);
    end
    checks++;
    if (out_p[0] !== 16'h0000 || spm_x[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_data out_p=%h spm_x=%h required 0000 00", out_p[0], spm_x[0]);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b required 1 0", in_ready[0], busy[0]);
    end
  endtask

  task automatic test_basic();
    int lat, cn, ca, ny;
    logic [31:0] ys;
    run_op(8'd13, 8'd11, 1'b1, lat, cn, ca, ys, ny);
    checks++;
    if (out_p[0] !== 16'h008F) begin
      errors++;
      $display("FAIL basic_p got %h required 008f", out_p[0]);
    end
    checks++;
    if (lat != 19) begin
      errors++;
      $display("FAIL basic_latency got %0d required 19", lat);
    end
    checks++;
    if (cn != 1 || ca != 1) begin
      errors++;
      $display("FAIL basic_clr count=%0d at=%0d required 1 at 1", cn, ca);
    end
    checks++;
    if (spm_x[0] !== 8'd13) begin
      errors++;
      $display("FAIL basic_spm_x got %h required 0d", spm_x[0]);
    end
    step();
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake out_valid=%b in_ready=%b required 0 1",
               out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_operands();
    logic [7:0] xs [4];
    logic [7:0] ysv [4];
    int lat, cn, ca, ny;
    logic [31:0] ys;
    logic [15:0] e;
    xs[0] = 8'hFF; ysv[0] = 8'hFF;
    xs[1] = 8'h00; ysv[1] = 8'hA5;
    xs[2] = 8'h01; ysv[2] = 8'hA5;
    xs[3] = 8'h80; ysv[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], ysv[i], 1'b1, lat, cn, ca, ys, ny);
      e = 16'(xs[i]) * 16'(ysv[i]);
      checks++;
      if (out_p[0] !== e) begin
        errors++;
        $display("FAIL operand_p x=%h y=%h got %h required %h", xs[i], ysv[i], out_p[0], e);
      end
      checks++;
      if (ny != 17 || ys !== exp_yseq(ysv[i])) begin
        errors++;
        $display("FAIL operand_yseq y=%h got %0d bits %h required 17 bits %h",
                 ysv[i], ny, ys, exp_yseq(ysv[i]));
      end
      step();
    end
  endtask

  task automatic test_random();
    int lat, cn, ca, ny;
    logic [31:0] ys;
    logic [7:0] x, y;
    logic [15:0] e;
    for (int i = 0; i < 8; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      run_op(x, y, 1'b1, lat, cn, ca, ys, ny);
      e = 16'(x) * 16'(y);
      checks++;
      if (out_p[0] !== e || lat != 19) begin
        errors++;
        $display("FAIL random_op x=%h y=%h got %h at %0d required %h at 19",
                 x, y, out_p[0], lat, e);
      end
      step();
    end
  endtask

  task automatic test_stall();
    int lat, cn, ca, ny, c;
    logic [31:0] ys;
    logic [15:0] e1, e2;
    e1 = 16'd77 * 16'd9;
    e2 = 16'd200 * 16'd3;
    run_op(8'd77, 8'd9, 1'b0, lat, cn, ca, ys, ny);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_x = 8'(8'hC0 + i);
      in_y = 8'h5A;
      checks++;
      if (out_valid[0] !== 1'b1 || out_p[0] !== e1 || in_ready[0] !== 1'b0 ||
          spm_x[0] !== 8'd77 || spm_clr[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b p=%h rdy=%b x=%h clr=%b required 1 %h 0 4d 0",
                 i, out_valid[0], out_p[0], in_ready[0], spm_x[0], spm_clr[0], e1);
      end
      step();
    end
    in_x = 8'd200;
    in_y = 8'd3;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL stall_release out_valid=%b in_ready=%b required 0 1",
               out_valid[0], in_ready[0]);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (spm_clr[0] !== 1'b1 || spm_x[0] !== 8'd200) begin
      errors++;
      $display("FAIL stall_next_accept clr=%b spm_x=%h required 1 c8", spm_clr[0], spm_x[0]);
    end
    c = 0;
    while (!out_valid[0] && c < 40) begin
      step();
      c++;
    end
    checks++;
    if (out_valid[0] !== 1'b1 || out_p[0] !== e2) begin
      errors++;
      $display("FAIL stall_next_p valid=%b got %h required 1 %h", out_valid[0], out_p[0], e2);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int lat, cn, ca, ny, c;
    logic [31:0] ys;
    logic seen;
    in_x = 8'd200; in_y = 8'd200; in_valid = 1'b1; out_ready = 1'b1;
    c = 0;
    while (!in_ready[0] && c < 40) begin
      step();
      c++;
    end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0 ||
        spm_clr[0] !== 1'b0 || out_p[0] !== 16'h0000) begin
      errors++;
      $display("FAIL midrun_reset rdy=%b busy=%b valid=%b clr=%b p=%h required 1 0 0 0 0000",
               in_ready[0], busy[0], out_valid[0], spm_clr[0], out_p[0]);
    end
    step();
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid[0]) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrun_abandon out_valid seen=%b required 0", seen);
    end
    run_op(8'd3, 8'd7, 1'b1, lat, cn, ca, ys, ny);
    checks++;
    if (out_p[0] !== 16'h0015 || lat != 19) begin
      errors++;
      $display("FAIL midrun_next got %h at %0d required 0015 at 19", out_p[0], lat);
    end
    step();
  endtask

  task automatic test_lat_sweep();
    int lats [NI];
    logic [15:0] ps [NI];
    int explat [NI];
    logic [7:0] x, y;
    logic [15:0] e;
    explat[0] = 19; explat[1] = 18; explat[2] = 21;
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      x = (t == 0) ? 8'd13 : 8'($urandom);
      y = (t == 0) ? 8'd11 : 8'($urandom);
      e = 16'(x) * 16'(y);
      in_x = x; in_y = y; in_valid = 1'b1; out_ready = 1'b1;
      checks++;
      if (in_ready[0] !== 1'b1 || in_ready[1] !== 1'b1 || in_ready[2] !== 1'b1) begin
        errors++;
        $display("FAIL sweep_idle ready=%b%b%b required 111", in_ready[0], in_ready[1],
                 in_ready[2]);
      end
      for (int g = 0; g < NI; g++) begin
        lats[g] = -1;
        ps[g] = '0;
      end
      step();
      in_valid = 1'b0;
      for (int k = 1; k < 40; k++) begin
        for (int g = 0; g < NI; g++) begin
          if (out_valid[g] && lats[g] < 0) begin
            lats[g] = k;
            ps[g] = out_p[g];
          end
        end
        step();
      end
      for (int g = 0; g < NI; g++) begin
        checks++;
        if (lats[g] != explat[g] || ps[g] !== e) begin
          errors++;
          $display("FAIL sweep inst=%0d x=%h y=%h got %h at %0d required %h at %0d",
                   g, x, y, ps[g], lats[g], e, explat[g]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    in_y = '0;
    test_reset();
    test_basic();
    test_operands();
    test_random();
    test_stall();
    test_reset_mid_run();
    test_lat_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spm_seq_ctrl.md
Name: spm_seq_ctrl

Overview:
- Sequencer for the serial-parallel multiplier (spm) and its carry-save adder chain (genblk1[*].csa).
- Accepts one operand pair over a valid/ready handshake and holds the multiplicand on the array's parallel x inputs.
- Clears the csa sum/carry state, then streams the multiplier LSB-first into the serial y input.
- Deserialises the serial product into a full-width word returned over a second valid/ready handshake. One operation in flight at a time.

Parameters:
- XW, 8, multiplicand width; must equal spm array width.
- YW, 8, multiplier width.
- SPM_LAT, 1, cycles from a y bit on spm_y to the matching product bit on spm_p; legal range 0..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- in_x  in  XW  multiplicand, unsigned.
- in_y  in  YW  multiplier, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_p  out  XW+YW  product, unsigned.
- busy  out  1  high in CLEAR/RUN/DONE.
- spm_clr  out  1  synchronous clear pulse to spm csa sum/carry flops, active-high.
- spm_x  out  XW  parallel multiplicand to array.
- spm_y  out  1  serial multiplier bit to array.
- spm_p  in  1  serial product bit from array.

Behaviour:
- Reset (rst=0, async): state=IDLE; cnt=0. Registered outputs go to 0: out_p, spm_x, spm_y, out_valid, spm_clr. in_ready is 1 after reset releases. Reset mid-RUN/DONE abandons the operation; no partial product is emitted.
- FSM states IDLE, CLEAR, RUN, DONE. All outputs are registered or decoded from state only; no in→out combinational path.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x into spm_x, y into yreg, clear preg, go to CLEAR.
- CLEAR:
  - spm_clr=1 for exactly one cycle; spm_y=0.
  - Next state RUN with cnt=0.
- RUN:
  - Lasts N=XW+YW+SPM_LAT cycles; cnt counts 0..N-1.
  - Each cycle, spm_y=yreg[0] while cnt<YW, else 0. Zero-fill flushes the carries.
  - yreg shifts right by 1 each cycle.
  - When cnt>=SPM_LAT, spm_p shifts into preg MSB with a right shift. After N cycles preg holds the product LSB-aligned.
  - At cnt==N-1, go to DONE.
- DONE:
  - out_valid=1; out_p=preg, stable until handshake.
  - On out_ready: go to IDLE.
  - out_valid falls the cycle after the handshake.
- spm_x holds its value from accept until the next accept.
- in_ready=0 in CLEAR/RUN/DONE. in_valid in those states is ignored and not queued; operands are not sampled.
- No back-to-back overlap: the earliest next accept is the cycle after the DONE handshake. Throughput is 1 op per N+3 cycles minimum.
- Latency: accept in cycle 0 → out_valid in cycle N+2. With defaults this is cycle 19.
- cnt width is $clog2(N+1). There is no wrap; cnt resets to 0 on entry to RUN.
- out_ready while not in DONE is ignored.

Decomposition:
- Shared package spm_pkg:
  - state enum (IDLE, CLEAR, RUN, DONE).
  - localparam function for counter width.
  - default widths.
- One natural sub-module, spm_serdes: y shift-out and p shift-in with SPM_LAT capture gating, driven by cnt. The FSM stays in spm_seq_ctrl.

Test Plan:
- Basic multiply: x=13, y=11, out_ready=1 → out_valid in cycle 19, out_p=0x008F. spm_clr high for exactly one cycle (cycle 1).
- Max operands: x=0xFF, y=0xFF → out_p=0xFE01. spm_y sequence is 1×8 then 0×9.
- Zero and one: x=0x00, y=0xA5 → 0x0000; then x=0x01, y=0xA5 → 0x00A5.
- Output stall: out_ready=0 for 10 cycles in DONE → out_p stable, in_ready=0. A new in_valid is ignored; after out_ready=1, the next op is accepted the following cycle.
- Async reset mid-RUN: assert rst=0 at cnt=5 → immediate IDLE. out_valid=0, spm_clr=0, in_ready=1 after release. The next op x=3, y=7 yields 0x0015.
- Latency sweep: SPM_LAT=0 and 3 with a behavioural spm model → out_p correct. out_valid at cycles 18 and 21 respectively.
